// File: rtl/fib_arbiter.sv
// fib_arbiter: round-robin share of one Fibonacci core among NUM_REQ requesters.
// One job in flight; the result goes back to the requester that issued it.
module fib_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [32*NUM_REQ-1:0]    req_n,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic signed [31:0]       rsp_data,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  output logic                     core_ready,
  output logic signed [31:0]       core_in_n,
  input  logic                     core_valid,
  output logic                     core_accept,
  input  logic signed [31:0]       core_out
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t state;

  logic [IDW-1:0]     last;
  logic [IDW-1:0]     win;
  logic               hit;
  logic signed [31:0] arg;
  logic signed [31:0] result;

  function automatic logic [IDW-1:0] wrap_idx(
    input logic [IDW-1:0] base,
    input int             step
  );
    return IDW'((int'(base) + step) % NUM_REQ);
  endfunction

  // Walk from farthest to nearest so the nearest valid after last wins.
  always_comb begin
    win = last;
    hit = |req_valid;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_valid[wrap_idx(last, i)]) begin
        win = wrap_idx(last, i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IDW'(NUM_REQ - 1);
      grant_id <= '0;
      arg      <= '0;
      result   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            arg      <= req_n[32*win +: 32];
            grant_id <= win;
            state    <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (core_valid) begin
            result <= core_out;
            state  <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant_id]) begin
            last  <= grant_id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && hit) begin
      req_ready[win] = 1'b1;
    end
    if (state == RESP) begin
      rsp_valid[grant_id] = 1'b1;
    end
  end

  // The core's valid flag is only trusted while a job is outstanding.
  assign core_accept = (state == WAIT) && core_valid;
  assign core_ready  = (state == START);
  assign core_in_n   = core_ready ? arg : '0;
  assign busy        = (state != IDLE);
  assign rsp_data    = result;

endmodule
